pe_fire_ctrl: RTL and testbench

PE_FIRE_CTRL -- requirements
Module: pe_fire_ctrl

---
 rtl/pe_fire_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_pe_fire_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_fire_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pe_fire_ctrl
//  Description : Fire controller for a processing element. Latches a
//                configuration word, collects operands A and B (or A alone in
//                single-operand mode), issues one operation at a time to an
//                external functional unit, and buffers results in a small
//                output FIFO. Issue is credit-gated so a result never arrives
//                at a full FIFO.
//  Ports       : clk, rst             - clock, synchronous active-high reset
//                clear                - soft clear back to unconfigured
//                cfg_valid/cfg/cfgd   - configuration load / done
//                a_*/b_*              - operand channels (valid/ready)
//                fu_*                 - functional-unit issue and completion
//                out_*                - result channel (valid/ready)
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_fire_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  cfg_valid,
    input  logic [DATA_WIDTH-1:0] cfg,
    output logic                  cfgd,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  fu_start,
    output logic [DATA_WIDTH-1:0] fu_a,
    output logic [DATA_WIDTH-1:0] fu_b,
    output logic [4:0]            fu_op,
    input  logic                  fu_ready,
    input  logic                  fu_done,
    input  logic [DATA_WIDTH-1:0] fu_result,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready
);

    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] C_DEPTH = OUT_DEPTH[CNT_W:0];

    typedef enum logic [1:0] {
        S_UNCFG = 2'd0,
        S_IDLE  = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_fire;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_fire_ok;
    logic                  w_a_hs;
    logic                  w_b_hs;
    logic [CNT_W:0]        w_credit_used;

    logic [4:0]            r_op;
    logic                  r_single;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic                  r_a_full;
    logic                  r_b_full;
    logic                  r_inflight;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [DATA_WIDTH-1:0] r_mem [OUT_DEPTH];

    // Only op and mode bits of the configuration word are meaningful.
    logic w_cfg_unused;
    assign w_cfg_unused = ^cfg[DATA_WIDTH-1:6];

    // ------------------------------------------------------------------------
    // Handshakes and issue credit
    // ------------------------------------------------------------------------
    assign w_a_hs = a_valid && a_ready;
    assign w_b_hs = b_valid && b_ready;
    assign w_pop  = out_valid && out_ready;

    // Buffered results plus the one that may still come back must fit.
    assign w_credit_used = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
    assign w_fire_ok     = r_a_full && (r_b_full || r_single) && fu_ready &&
                           (w_credit_used < C_DEPTH);

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_state <= S_UNCFG;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fire      = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            S_UNCFG: begin
                if (cfg_valid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (w_fire_ok) begin
                    w_fire      = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (fu_done) begin
                    w_push      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_UNCFG;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Configuration, operand registers, in-flight flag and FIFO bookkeeping
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op       <= '0;
            r_single   <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_a_full   <= 1'b0;
            r_b_full   <= 1'b0;
            r_inflight <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else if (clear) begin
            r_op       <= '0;
            r_single   <= 1'b0;
            r_a_full   <= 1'b0;
            r_b_full   <= 1'b0;
            r_inflight <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (r_state == S_UNCFG && cfg_valid) begin
                r_op     <= cfg[4:0];
                r_single <= cfg[5];
            end
            if (w_a_hs) begin
                r_a <= a_data;
            end
            if (w_b_hs) begin
                r_b <= b_data;
            end
            // A fire empties the register; a handshake in the same cycle refills it.
            r_a_full <= (r_a_full && !w_fire) || w_a_hs;
            r_b_full <= (r_b_full && !w_fire) || w_b_hs;

            if (w_fire) begin
                r_inflight <= 1'b1;
            end else if (w_push) begin
                r_inflight <= 1'b0;
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (!rst && !clear && w_push) begin
            r_mem[r_wr_ptr] <= fu_result;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign cfgd      = (r_state != S_UNCFG);
    assign a_ready   = (r_state != S_UNCFG) && !r_a_full;
    assign b_ready   = (r_state != S_UNCFG) && !r_single && !r_b_full;
    assign fu_start  = w_fire;
    assign fu_op     = r_op;
    assign fu_a      = r_a;
    assign fu_b      = r_single ? '0 : r_b;
    assign out_valid = (r_count != '0);
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;

endmodule
`default_nettype wire

// File: tb/tb_pe_fire_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pe_fire_ctrl
//  Description : Self-checking bench for pe_fire_ctrl: table of two-operand
//                operations plus hand-written sequences for single-operand
//                mode, FIFO backpressure/wrap, soft clear and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_fire_ctrl;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [DW-1:0] cfg = '0;
    logic          cfgd;
    logic          a_valid = 1'b0;
    logic          a_ready;
    logic [DW-1:0] a_data = '0;
    logic          b_valid = 1'b0;
    logic          b_ready;
    logic [DW-1:0] b_data = '0;
    logic          fu_start;
    logic [DW-1:0] fu_a;
    logic [DW-1:0] fu_b;
    logic [4:0]    fu_op;
    logic          fu_ready = 1'b1;
    logic          fu_done = 1'b0;
    logic [DW-1:0] fu_result = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;

    always #5 clk = ~clk;

    pe_fire_ctrl #(.DATA_WIDTH(DW), .OUT_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .cfg_valid(cfg_valid), .cfg(cfg), .cfgd(cfgd),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
        .fu_start(fu_start), .fu_a(fu_a), .fu_b(fu_b), .fu_op(fu_op),
        .fu_ready(fu_ready), .fu_done(fu_done), .fu_result(fu_result),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Inputs change and outputs are sampled at the falling edge.
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic configure(input logic [DW-1:0] word);
        cfg_valid = 1'b1;
        cfg       = word;
        tick();
        cfg_valid = 1'b0;
        check("cfgd_after_cfg", cfgd, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cfgd"},      cfgd, 0);
        check({tag, "_a_ready"},   a_ready, 0);
        check({tag, "_b_ready"},   b_ready, 0);
        check({tag, "_fu_start"},  fu_start, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_fu_op"},     fu_op, 0);
        check({tag, "_fu_a"},      fu_a, 0);
        check({tag, "_fu_b"},      fu_b, 0);
        check({tag, "_out_data"},  out_data, 0);
    endtask

    // Present operands together; FU completes 2 cycles after fu_start.
    task automatic do_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] res, input logic use_b);
        a_valid = 1'b1;
        a_data  = a;
        b_valid = use_b;
        b_data  = b;
        tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
        check("op_fu_start", fu_start, 1);
        check("op_fu_a", fu_a, a);
        check("op_fu_b", fu_b, use_b ? b : '0);
        tick();
        check("op_start_one_cycle", fu_start, 0);
        tick();
        fu_done   = 1'b1;
        fu_result = res;
        tick();
        fu_done = 1'b0;
        check("op_out_valid", out_valid, 1);
    endtask

    task automatic drain(input logic [DW-1:0] exp);
        check("drain_valid", out_valid, 1);
        check("drain_data", out_data, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] res;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{a: 32'd5,          b: 32'd7,          res: 32'd12};
        vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'h0000_0001,  res: 32'h0000_0000};
        vecs[2] = '{a: 32'h0000_A5A5,  b: 32'h0000_5A5A,  res: 32'h0000_FFFF};
        vecs[3] = '{a: 32'h8000_0000,  b: 32'h7FFF_FFFF,  res: 32'hFFFF_FFFF};

        @(negedge clk);
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();
        check("uncfg_a_ready", a_ready, 0);

        // Two-operand configuration, op 3.
        configure(32'h03);
        check("cfg_fu_op", fu_op, 5'd3);
        check("cfg_b_ready", b_ready, 1);
        // Reconfiguration attempts outside UNCFG are ignored.
        cfg_valid = 1'b1;
        cfg       = 32'h3F;
        tick();
        cfg_valid = 1'b0;
        check("cfg_ignored_op", fu_op, 5'd3);
        check("cfg_ignored_b_ready", b_ready, 1);

        for (int i = 0; i < 4; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].res, 1'b1);
            check("tbl_fu_op", fu_op, 5'd3);
            drain(vecs[i].res);
            check("tbl_empty", out_valid, 0);
        end

        // Operands arriving in different cycles: fire waits for B.
        a_valid = 1'b1;
        a_data  = 32'h11;
        tick();
        a_valid = 1'b0;
        check("seq_no_fire_without_b", fu_start, 0);
        check("seq_a_full", a_ready, 0);
        b_valid = 1'b1;
        b_data  = 32'h22;
        tick();
        b_valid = 1'b0;
        check("seq_fire", fu_start, 1);
        check("seq_fu_b", fu_b, 32'h22);
        tick();
        tick();
        fu_done   = 1'b1;
        fu_result = 32'h33;
        tick();
        fu_done = 1'b0;
        drain(32'h33);

        // fu_done while IDLE is ignored.
        fu_done   = 1'b1;
        fu_result = 32'hBAD;
        tick();
        fu_done = 1'b0;
        check("done_in_idle_ignored", out_valid, 0);

        // Single-operand mode.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_cfgd", cfgd, 0);
        check("clear_a_ready", a_ready, 0);
        configure(32'h21);
        check("single_fu_op", fu_op, 5'd1);
        check("single_b_ready", b_ready, 0);
        do_op(32'd9, 32'd0, 32'd9, 1'b0);
        check("single_b_ready_after", b_ready, 0);
        drain(32'd9);

        // Backpressure: four buffered results exhaust the credit.
        for (int v = 1; v <= 4; v++) do_op(DW'(v), '0, DW'(v), 1'b0);
        check("bp_head", out_data, 32'd1);
        a_valid = 1'b1;
        a_data  = 32'd5;
        tick();
        a_valid = 1'b0;
        check("bp_fifth_accepted", a_ready, 0);
        check("bp_no_fire", fu_start, 0);
        tick();
        tick();
        check("bp_still_no_fire", fu_start, 0);
        drain(32'd1);
        check("bp_fire_after_pop", fu_start, 1);
        check("bp_fire_a", fu_a, 32'd5);
        tick();
        a_valid = 1'b1;
        a_data  = 32'd6;
        check("wait_accepts_a", a_ready, 1);
        tick();
        a_valid = 1'b0;
        // Push and pop in the same cycle.
        fu_done   = 1'b1;
        fu_result = 32'd5;
        out_ready = 1'b1;
        check("pushpop_head", out_data, 32'd2);
        tick();
        fu_done   = 1'b0;
        out_ready = 1'b0;
        check("pushpop_count_kept_fire", fu_start, 1);
        check("pushpop_fire_a", fu_a, 32'd6);
        tick();
        fu_done   = 1'b1;
        fu_result = 32'd6;
        tick();
        fu_done = 1'b0;
        for (int v = 3; v <= 6; v++) drain(DW'(v));
        check("wrap_empty", out_valid, 0);
        do_op(32'd7, '0, 32'd7, 1'b0);
        do_op(32'd8, '0, 32'd8, 1'b0);
        drain(32'd7);
        drain(32'd8);
        check("wrap_empty2", out_valid, 0);

        // Clear while WAIT, with cfg_valid in the same cycle.
        do_op(32'h77, '0, 32'h77, 1'b0);
        a_valid = 1'b1;
        a_data  = 32'h10;
        tick();
        a_valid = 1'b0;
        check("clr_fire", fu_start, 1);
        tick();
        clear     = 1'b1;
        cfg_valid = 1'b1;
        cfg       = 32'h03;
        tick();
        clear     = 1'b0;
        cfg_valid = 1'b0;
        check("clr_cfgd", cfgd, 0);
        check("clr_out_valid", out_valid, 0);
        check("clr_a_ready", a_ready, 0);
        fu_done   = 1'b1;
        fu_result = 32'hDEAD;
        tick();
        fu_done = 1'b0;
        check("clr_late_done_ignored", out_valid, 0);
        check("clr_still_uncfg", cfgd, 0);

        // Reset with two buffered results and one in flight.
        configure(32'h03);
        do_op(32'd1, 32'd2, 32'd3, 1'b1);
        do_op(32'd4, 32'd5, 32'd9, 1'b1);
        a_valid = 1'b1;
        a_data  = 32'd10;
        b_valid = 1'b1;
        b_data  = 32'd20;
        tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
        check("rst_third_fire", fu_start, 1);
        tick();
        rst = 1'b1;
        tick();
        check_all_zero("midrst");
        rst       = 1'b0;
        fu_done   = 1'b1;
        fu_result = 32'h55;
        a_valid   = 1'b1;
        b_valid   = 1'b1;
        tick();
        fu_done = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        check("postrst_no_fire", fu_start, 0);
        check("postrst_out_valid", out_valid, 0);
        check("postrst_a_ready", a_ready, 0);
        configure(32'h03);
        do_op(32'd2, 32'd3, 32'd5, 1'b1);
        drain(32'd5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got %0d checks, expected completion", n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
